// File: rtl/lcd_read_fsm.sv
// Character-LCD byte read over SF_D[11:8]: two E-strobed nibble reads, high nibble first.
// Optional macro LCD_BUSY_POLL_EN: re-read rs=0 (busy flag) until BF=0 or MAX_POLLS is reached.
module lcd_read_fsm #(
  parameter int unsigned T_SETUP  = 2,
  parameter int unsigned T_E_HIGH = 12,
  parameter int unsigned T_HOLD   = 1,
  parameter int unsigned T_GAP    = 50
`ifdef LCD_BUSY_POLL_EN
  ,
  parameter int unsigned MAX_POLLS = 255
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rs,
  input  logic [3:0] sf_d_in,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic       sf_d_oe,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [3:0] {
    IDLE, SETUP_HIGH, ACTIVE_HIGH, HOLD_HIGH, WAIT,
    SETUP_LOW, ACTIVE_LOW, HOLD_LOW, DONE
  } state_t;

  localparam logic [11:0] LAST_SETUP = 12'(T_SETUP - 1);
  localparam logic [11:0] LAST_E     = 12'(T_E_HIGH - 1);
  localparam logic [11:0] LAST_HOLD  = 12'(T_HOLD - 1);
  localparam logic [11:0] LAST_GAP   = 12'(T_GAP - 1);

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic        rs_q, rs_d;
  logic        lcd_rs_q, lcd_rw_q, lcd_e_q, oe_q, valid_q, busy_q;
  logic [7:0]  data_q;

`ifdef LCD_BUSY_POLL_EN
  localparam logic [7:0] LAST_POLL = 8'(MAX_POLLS - 1);
  logic       poll_wait_q, poll_wait_d;
  logic [7:0] polls_q, polls_d;
  logic       timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    rs_d    = rs_q;
`ifdef LCD_BUSY_POLL_EN
    poll_wait_d = poll_wait_q;
    polls_d     = polls_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = SETUP_HIGH;
        rs_d    = rs;
`ifdef LCD_BUSY_POLL_EN
        polls_d     = '0;
        poll_wait_d = 1'b0;
`endif
      end
      SETUP_HIGH:  if (cnt_q == LAST_SETUP) state_d = ACTIVE_HIGH;
      ACTIVE_HIGH: if (cnt_q == LAST_E)     state_d = HOLD_HIGH;
      HOLD_HIGH:   if (cnt_q == LAST_HOLD)  state_d = WAIT;
      WAIT: if (cnt_q == LAST_GAP) begin
`ifdef LCD_BUSY_POLL_EN
        state_d     = poll_wait_q ? SETUP_HIGH : SETUP_LOW;
        poll_wait_d = 1'b0;
`else
        state_d = SETUP_LOW;
`endif
      end
      SETUP_LOW:   if (cnt_q == LAST_SETUP) state_d = ACTIVE_LOW;
      ACTIVE_LOW:  if (cnt_q == LAST_E)     state_d = HOLD_LOW;
      HOLD_LOW: if (cnt_q == LAST_HOLD) begin
        state_d = DONE;
`ifdef LCD_BUSY_POLL_EN
        // BF sits in the already-captured high nibble; a busy LCD is polled again after a gap
        if (!rs_q && data_q[7]) begin
          if (polls_q == LAST_POLL) begin
            timeout_d = 1'b1;
          end else begin
            state_d     = WAIT;
            poll_wait_d = 1'b1;
            polls_d     = polls_q + 8'd1;
          end
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 12'd1;
  end

  // Outputs are decoded from the next state so each registered output lines up with its state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rs_q     <= 1'b0;
      lcd_rs_q <= 1'b0;
      lcd_rw_q <= 1'b0;
      lcd_e_q  <= 1'b0;
      oe_q     <= 1'b1;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      poll_wait_q <= 1'b0;
      polls_q     <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rs_q     <= rs_d;
      lcd_e_q  <= (state_d == ACTIVE_HIGH) || (state_d == ACTIVE_LOW);
      lcd_rw_q <= (state_d != IDLE) && (state_d != DONE);
      lcd_rs_q <= (state_d != IDLE) && (state_d != DONE) && rs_d;
      oe_q     <= (state_d == IDLE);
      busy_q   <= (state_d != IDLE);
      valid_q  <= (state_d == DONE);
      if (state_q == ACTIVE_HIGH && state_d == HOLD_HIGH) data_q[7:4] <= sf_d_in;
      if (state_q == ACTIVE_LOW && state_d == HOLD_LOW)   data_q[3:0] <= sf_d_in;
`ifdef LCD_BUSY_POLL_EN
      poll_wait_q <= poll_wait_d;
      polls_q     <= polls_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign LCD_RS   = lcd_rs_q;
  assign LCD_RW   = lcd_rw_q;
  assign LCD_E    = lcd_e_q;
  assign sf_d_oe  = oe_q;
  assign rd_data  = data_q;
  assign rd_valid = valid_q;
  assign busy     = busy_q;
`ifdef LCD_BUSY_POLL_EN
  assign timeout  = timeout_q;
`else
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_read_fsm.sv
// Directed bench for lcd_read_fsm; cycle 0 is the cycle in which start is sampled.
// Poll-mode vectors are built only when LCD_BUSY_POLL_EN is defined.
module tb_lcd_read_fsm;
  logic       clk = 1'b0;
  logic       reset, start, rs;
  logic [3:0] sf_d_in;
  logic       LCD_RS, LCD_RW, LCD_E, sf_d_oe, rd_valid, busy, timeout;
  logic [7:0] rd_data;

  int checks = 0;
  int failures = 0;

  bit       a_e[0:1023], a_rw[0:1023], a_rs[0:1023], a_oe[0:1023];
  bit       a_v[0:1023], a_b[0:1023], a_to[0:1023];
  bit [7:0] a_d[0:1023];
  int       rises;

  always #5 clk = ~clk;

  lcd_read_fsm u_dut (
    .clk(clk), .reset(reset), .start(start), .rs(rs), .sf_d_in(sf_d_in),
    .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_E(LCD_E), .sf_d_oe(sf_d_oe),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .timeout(timeout)
  );

`ifdef LCD_BUSY_POLL_EN
  logic       start2;
  logic [3:0] sf_d_in2 = 4'h8;
  logic       rs2_o, rw2_o, e2_o, oe2_o, v2_o, b2_o, to2_o;
  logic [7:0] d2_o;
  int         v2, rises2;
  logic       v2_to;
  logic [7:0] v2_data;
  bit         e2_prev;

  lcd_read_fsm #(.MAX_POLLS(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .rs(1'b0), .sf_d_in(sf_d_in2),
    .LCD_RS(rs2_o), .LCD_RW(rw2_o), .LCD_E(e2_o), .sf_d_oe(oe2_o),
    .rd_data(d2_o), .rd_valid(v2_o), .busy(b2_o), .timeout(to2_o)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain read, 1: stray start pulses, 2: reset at cycle 8, 3: busy-flag polling
  task automatic run_txn(input logic rs_v, input logic [3:0] hi, input logic [3:0] lo,
                         input int mode, input int ncyc);
    rises = 0;
    a_e[0] = LCD_E; a_rw[0] = LCD_RW; a_rs[0] = LCD_RS; a_oe[0] = sf_d_oe;
    a_v[0] = rd_valid; a_b[0] = busy; a_to[0] = timeout; a_d[0] = rd_data;
    start = 1'b1;
    rs = rs_v;
    sf_d_in = (mode == 3) ? 4'h8 : hi;
`ifdef LCD_BUSY_POLL_EN
    v2 = 0; rises2 = 0; v2_to = 1'b0; v2_data = '0; e2_prev = 1'b0;
    if (mode == 3) start2 = 1'b1;
`endif
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      a_e[c] = LCD_E; a_rw[c] = LCD_RW; a_rs[c] = LCD_RS; a_oe[c] = sf_d_oe;
      a_v[c] = rd_valid; a_b[c] = busy; a_to[c] = timeout; a_d[c] = rd_data;
      if (LCD_E && !a_e[c-1]) rises++;
`ifdef LCD_BUSY_POLL_EN
      start2 = 1'b0;
      if (e2_o && !e2_prev) rises2++;
      e2_prev = e2_o;
      if (v2_o) begin v2++; v2_to = to2_o; v2_data = d2_o; end
`endif
      if (mode == 3)       sf_d_in = (rises < 7) ? 4'h8 : 4'h0;
      else if (c <= 14)    sf_d_in = hi;
      else if (c == 15)    sf_d_in = 4'hF;
      else if (c <= 79)    sf_d_in = lo;
      else                 sf_d_in = 4'hF;
      if (mode == 1 && (c == 10 || c == 40)) start = 1'b1;
      if (mode == 2) reset = (c == 8);
    end
  endtask

  int first_e, e_lo, e_hi, rwrs_bad, e_stab_bad, contention, vcount, first_v;
  int rw_fall, oe_rise, rs_ones, to_ones;

  task automatic analyse(input int ncyc);
    first_e = -1; e_lo = 0; e_hi = 0; rwrs_bad = 0; e_stab_bad = 0; contention = 0;
    vcount = 0; first_v = -1; rw_fall = -1; oe_rise = -1; rs_ones = 0; to_ones = 0;
    for (int c = 0; c <= ncyc; c++) begin
      if (a_e[c] && first_e < 0) first_e = c;
      if (a_e[c] && c <= 40) e_lo++;
      if (a_e[c] && c > 40) e_hi++;
      if (c >= 1 && c <= 80 && !a_rw[c]) rwrs_bad++;
      if (c >= 1 && (a_e[c] || a_e[c-1]) && (a_rw[c] != a_rw[c-1] || a_rs[c] != a_rs[c-1]))
        e_stab_bad++;
      if (a_oe[c] && a_rw[c]) contention++;
      if (a_v[c]) begin vcount++; if (first_v < 0) first_v = c; end
      if (c >= 2 && !a_rw[c] && a_rw[c-1] && rw_fall < 0) rw_fall = c;
      if (c >= 2 && a_oe[c] && !a_oe[c-1] && oe_rise < 0) oe_rise = c;
      if (a_rs[c]) rs_ones++;
      if (a_to[c]) to_ones++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rs = 1'b0; sf_d_in = 4'h0;
`ifdef LCD_BUSY_POLL_EN
    start2 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_e", LCD_E, 0);
    check("rst_rw", LCD_RW, 0);
    check("rst_rs", LCD_RS, 0);
    check("rst_oe", sf_d_oe, 1);
    check("rst_data", rd_data, 8'h00);
    check("rst_valid", rd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);

    // rs=1 read of 0xA5, sf_d_in glitches to F right after each E fall
    run_txn(1'b1, 4'hA, 4'h5, 0, 95);
    analyse(95);
    check("t1_busy_c1", a_b[1], 1);
    check("t1_first_e", first_e, 3);
    check("t1_e_pulse1", e_lo, 12);
    check("t1_e_pulse2", e_hi, 12);
    check("t1_e_c14", a_e[14], 1);
    check("t1_e_c15", a_e[15], 0);
    check("t1_e_c67", a_e[67], 0);
    check("t1_e_c79", a_e[79], 1);
    check("t1_rw_held", rwrs_bad, 0);
    check("t1_rs_ones", rs_ones, 80);
    check("t1_e_stable", e_stab_bad, 0);
    check("t1_data_c15", a_d[15], 8'hA0);
    check("t1_data_c16", a_d[16], 8'hA0);
    check("t1_vcount", vcount, 1);
    check("t1_first_v", first_v, 81);
    check("t1_data_v", a_d[81], 8'hA5);
    check("t1_busy_c81", a_b[81], 1);
    check("t1_busy_c82", a_b[82], 0);
    check("t1_rw_fall", rw_fall, 81);
    check("t1_oe_rise", oe_rise, 82);
    check("t1_oe_c1", a_oe[1], 0);
    check("t1_contention", contention, 0);
    check("t1_data_hold", a_d[95], 8'hA5);
    check("t1_timeout", to_ones, 0);

    // rs=0 read of 0x3C with ignored start pulses at cycles 10 and 40
    run_txn(1'b0, 4'h3, 4'hC, 1, 100);
    analyse(100);
    check("t2_vcount", vcount, 1);
    check("t2_first_v", first_v, 81);
    check("t2_data_v", a_d[81], 8'h3C);
    check("t2_rs_low", rs_ones, 0);
    check("t2_contention", contention, 0);

    // reset while E is high
    run_txn(1'b1, 4'h6, 4'h9, 2, 100);
    analyse(100);
    check("t3_e_c8", a_e[8], 1);
    check("t3_e_c9", a_e[9], 0);
    check("t3_busy_c9", a_b[9], 0);
    check("t3_oe_c9", a_oe[9], 1);
    check("t3_rw_c9", a_rw[9], 0);
    check("t3_data_c9", a_d[9], 8'h00);
    check("t3_vcount", vcount, 0);
    check("t3_busy_end", a_b[100], 0);

`ifdef LCD_BUSY_POLL_EN
    // BF=1 for three reads then clear; second instance keeps BF=1 with MAX_POLLS=2
    run_txn(1'b0, 4'h0, 4'h0, 3, 700);
    analyse(700);
    check("t4_rises", rises, 8);
    check("t4_vcount", vcount, 1);
    check("t4_data_v", (first_v >= 0) ? a_d[first_v] : 8'hXX, 8'h00);
    check("t4_timeout", to_ones, 0);
    check("t5_vcount", v2, 1);
    check("t5_timeout", v2_to, 1);
    check("t5_data", v2_data, 8'h88);
    check("t5_rises", rises2, 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lcd_read_fsm.md
Name: lcd_read_fsm

Overview:
Reads one byte from the character LCD over the 4-bit SF_D[11:8] bus. This is the read-direction counterpart of the LCD instruction-write FSM. It performs two E-strobed nibble reads, high nibble first, with LCD_RW=1. It then presents the assembled byte, either the busy flag/address counter (rs=0) or DDRAM/CGRAM data (rs=1), to the LCD controller top. It owns its own cycle counter, so no external clk_cnt is needed. The top-level tristate on SF_D is driven via sf_d_oe.

Parameters:
T_SETUP, 2, cycles RS/RW stable before LCD_E rises (40 ns @ 50 MHz)
T_E_HIGH, 12, cycles LCD_E high per nibble (240 ns)
T_HOLD, 1, cycles RS/RW held after LCD_E falls
T_GAP, 50, cycles between the two nibbles (1 us)
MAX_POLLS, 255, busy-flag poll limit (only with LCD_BUSY_POLL_EN)

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high
start  input  1  request one read; accepted only when busy=0
rs  input  1  register select for this read; latched on accept
sf_d_in  input  4  SF_D[11:8] as seen at the pad input
LCD_RS  output  1  LCD register select
LCD_RW  output  1  LCD read/write (1 = read)
LCD_E  output  1  LCD enable strobe
sf_d_oe  output  1  FPGA drive enable for SF_D[11:8]; 0 = released to LCD
rd_data  output  8  assembled byte {high nibble, low nibble}
rd_valid  output  1  one-cycle pulse; rd_data valid
busy  output  1  transaction in progress
timeout  output  1  poll limit reached (tied 0 without macro)

Behaviour:
- Reset values (sync, highest priority): state=IDLE, counter=0, LCD_RS=0, LCD_RW=0, LCD_E=0, sf_d_oe=1, rd_data=0, rd_valid=0, busy=0, timeout=0.
- All outputs are registered.
- States: IDLE, SETUP_HIGH, ACTIVE_HIGH, HOLD_HIGH, WAIT, SETUP_LOW, ACTIVE_LOW, HOLD_LOW, DONE.
- Each non-IDLE state lasts its parameter count of cycles (SETUP=T_SETUP, ACTIVE=T_E_HIGH, HOLD=T_HOLD, WAIT=T_GAP, DONE=1).
- The 12-bit counter clears on every state change.
- IDLE: on start=1, latch rs, go to SETUP_HIGH, and set busy=1 the next cycle. start while busy=1 is ignored, with no queuing.
- SETUP_*/HOLD_*: LCD_RS=rs_lat, LCD_RW=1, LCD_E=0.
- ACTIVE_*: same as SETUP_*/HOLD_*, but LCD_E=1.
- WAIT: LCD_RW=1, LCD_E=0.
- LCD_E is high for exactly T_E_HIGH consecutive cycles per nibble.
- LCD_RS and LCD_RW never change while LCD_E=1.
- Sampling: sf_d_in is captured on the clock edge where LCD_E falls. The ACTIVE_HIGH capture loads rd_data[7:4]; the ACTIVE_LOW capture loads rd_data[3:0].
- DONE: rd_valid=1 for one cycle, LCD_RW=0, LCD_RS=0, then return to IDLE with busy=0.
- sf_d_oe=0 from SETUP_HIGH entry until one cycle after LCD_RW returns to 0, giving one cycle of bus turnaround. It is 1 only in IDLE.
- sf_d_oe=1 and LCD_RW=1 are never true in the same cycle.
- rd_data holds its value until the next capture.
- Latency with defaults: start sampled at cycle 0, first LCD_E rise at cycle 3, rd_valid at cycle 81.
- Reset mid-transaction: all outputs are at reset values after that edge, with LCD_E=0 immediately and no rd_valid. reset and start in the same cycle: reset wins.

Optional Feature:
LCD_BUSY_POLL_EN
- Defined:
  - For rs=0 reads, after HOLD_LOW, if rd_data[7]=1 (LCD busy), the FSM re-enters SETUP_HIGH after a further T_GAP WAIT. No rd_valid is issued for that read.
  - It repeats until rd_data[7]=0. rd_valid then fires once with the final byte.
  - An 8-bit poll counter limits the loop. When MAX_POLLS reads have completed with BF=1, DONE asserts rd_valid and timeout together for one cycle.
  - rs=1 reads are never repeated.
- Undefined: single read only. timeout is constant 0 and MAX_POLLS is unused.

Test Plan:
- Reset, then start with rs=1 and sf_d_in=4'hA during the high nibble and 4'h5 during the low nibble -> LCD_RW=1 and LCD_RS=1 throughout; two 12-cycle LCD_E pulses; rd_valid at cycle 81 with rd_data=8'hA5; busy drops at cycle 82.
- sf_d_in changed to 4'hF on the cycle after the LCD_E fall -> rd_data is unaffected and still holds the value present on the last LCD_E-high cycle.
- start pulsed at cycles 10 and 40 during a transaction -> ignored; exactly one rd_valid.
- reset asserted at cycle 8 (LCD_E high) -> LCD_E=0, busy=0, sf_d_oe=1 next cycle; rd_data=0; no rd_valid.
- Bus contention check over a full read -> never sf_d_oe=1 with LCD_RW=1; sf_d_oe rises one cycle after LCD_RW falls.
- LCD_BUSY_POLL_EN, rs=0, sf_d_in high nibble=4'h8 for 3 reads then 4'h0 -> four E-pulse pairs; single rd_valid with rd_data[7]=0, timeout=0. With MAX_POLLS=2 and BF held at 1 -> rd_valid and timeout=1 after 2 reads.
